// File: rtl/stim_player.sv
`default_nettype none
// ============================================================================
// Module   : stim_player
// Purpose  : Programmable stimulus sequencer for board-style I/O. Replays a
//            table of up to DEPTH {sw,key} vectors, each held for its own
//            dwell count, onto sw_out/key_out. Synthesizable, so the same
//            sequences can drive on-chip self-test as well as sim benches.
// Ports    : clk, rst_n              - clock (rising edge), async active-low reset
//            wr_en/wr_addr/wr_sw/
//            wr_key/wr_dwell         - table write port (accepted in IDLE only)
//            num_steps, loop_en      - playback length / wrap, sampled at start
//            start, stop             - begin / abort playback
//            sw_out, key_out         - driven vector
//            step_idx                - index of entry currently on outputs
//            busy, done, wr_err      - status (done/wr_err are 1-cycle pulses)
// Config   : STIM_PLAYER_TRACE_EN    - when defined, prints each vector load
//            and each completion (simulation only; no effect on behaviour)
// Revision : 1.0 - initial release
// ============================================================================
module stim_player #(
  parameter int SW_W    = 18,
  parameter int KEY_W   = 4,
  parameter int DEPTH   = 16,
  parameter int DWELL_W = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [SW_W-1:0]    wr_sw,
  input  logic [KEY_W-1:0]   wr_key,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [AW:0]        num_steps,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic [SW_W-1:0]    sw_out,
  output logic [KEY_W-1:0]   key_out,
  output logic [AW-1:0]      step_idx,
  output logic               busy,
  output logic               done,
  output logic               wr_err
);

  // num_steps is AW+1 bits wide, so DEPTH itself is always representable.
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t               r_state;
  logic [AW:0]          r_n;
  logic                 r_loop;
  logic [DWELL_W-1:0]   r_cnt;
  logic [AW-1:0]        r_idx;
  logic [SW_W-1:0]      r_sw_out;
  logic [KEY_W-1:0]     r_key_out;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_wr_err;

  logic [SW_W-1:0]      r_tbl_sw    [DEPTH];
  logic [KEY_W-1:0]     r_tbl_key   [DEPTH];
  logic [DWELL_W-1:0]   r_tbl_dwell [DEPTH];

  logic [AW:0]          w_n_start;
  logic                 w_is_last;
  logic                 w_load;
  logic [AW-1:0]        w_load_idx;
  logic                 w_finish;
  logic [DWELL_W-1:0]   w_load_cnt;

  // ------------------------------------------------------------------------
  // Vector table: writable only while idle; cleared by reset.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_sw[i]    <= '0;
        r_tbl_key[i]   <= '0;
        r_tbl_dwell[i] <= '0;
      end
    end else if (wr_en && (r_state == S_IDLE)) begin
      r_tbl_sw[wr_addr]    <= wr_sw;
      r_tbl_key[wr_addr]   <= wr_key;
      r_tbl_dwell[wr_addr] <= wr_dwell;
    end
  end

  // ------------------------------------------------------------------------
  // Sequencing decisions. The step compare is done in AW+1 bits so that a
  // full-depth table (n == DEPTH) does not alias to index 0.
  // ------------------------------------------------------------------------
  always_comb begin
    w_n_start  = (num_steps > c_depth) ? c_depth : num_steps;
    w_is_last  = ({1'b0, r_idx} == (r_n - 1'b1));
    w_load     = 1'b0;
    w_load_idx = '0;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_steps != '0) w_load   = 1'b1;
          else                 w_finish = 1'b1;
        end
      end
      S_PLAY: begin
        if (!stop && (r_cnt == '0)) begin
          if (!w_is_last) begin
            w_load     = 1'b1;
            w_load_idx = r_idx + 1'b1;
          end else if (r_loop) begin
            w_load     = 1'b1;
          end else begin
            w_finish   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // A zero dwell is treated as one cycle, so the counter preload is
    // max(dwell,1)-1.
    w_load_cnt = (r_tbl_dwell[w_load_idx] == '0) ? '0
               : (r_tbl_dwell[w_load_idx] - 1'b1);
  end

  // ------------------------------------------------------------------------
  // Playback FSM with registered outputs.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_loop    <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sw_out  <= '0;
      r_key_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_done   <= w_finish;
      r_wr_err <= wr_en && (r_state == S_PLAY);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n    <= w_n_start;
            r_loop <= loop_en;
            if (num_steps != '0) begin
              r_state <= S_PLAY;
              r_busy  <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (stop) begin
            // Abort: current vector stays on the outputs, no done pulse.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_finish) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_load) begin
        r_sw_out  <= r_tbl_sw[w_load_idx];
        r_key_out <= r_tbl_key[w_load_idx];
        r_idx     <= w_load_idx;
        r_cnt     <= w_load_cnt;
      end
    end
  end

  assign sw_out   = r_sw_out;
  assign key_out  = r_key_out;
  assign step_idx = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_err   = r_wr_err;

`ifdef STIM_PLAYER_TRACE_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && w_load)
      $display("stim_player: t=%0t step=%0d sw=%h key=%b", $time, w_load_idx,
               r_tbl_sw[w_load_idx], r_tbl_key[w_load_idx]);
    if (rst_n && w_finish)
      $display("stim_player: done");
  end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_stim_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_stim_player
// Purpose  : Directed self-checking bench for stim_player with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stim_player;

  localparam int SW_W    = 18;
  localparam int KEY_W   = 4;
  localparam int DEPTH   = 16;
  localparam int DWELL_W = 8;
  localparam int AW      = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [SW_W-1:0]    wr_sw;
  logic [KEY_W-1:0]   wr_key;
  logic [DWELL_W-1:0] wr_dwell;
  logic [AW:0]        num_steps;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic [SW_W-1:0]    sw_out;
  logic [KEY_W-1:0]   key_out;
  logic [AW-1:0]      step_idx;
  logic               busy;
  logic               done;
  logic               wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  stim_player #(
    .SW_W(SW_W), .KEY_W(KEY_W), .DEPTH(DEPTH), .DWELL_W(DWELL_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sw(wr_sw), .wr_key(wr_key),
    .wr_dwell(wr_dwell), .num_steps(num_steps), .loop_en(loop_en),
    .start(start), .stop(stop),
    .sw_out(sw_out), .key_out(key_out), .step_idx(step_idx),
    .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int addr, input int sw, input int key, input int dw);
    wr_en    = 1'b1;
    wr_addr  = AW'(addr);
    wr_sw    = SW_W'(sw);
    wr_key   = KEY_W'(key);
    wr_dwell = DWELL_W'(dw);
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic do_start(input int n, input logic lp);
    num_steps = (AW+1)'(n);
    loop_en   = lp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int exp_idx [9];
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_sw = '0; wr_key = '0;
    wr_dwell = '0; num_steps = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;

    // ---- 1: reset values ----
    tick(); tick();
    check_eq("rst_sw",   32'(sw_out),   0);
    check_eq("rst_key",  32'(key_out),  0);
    check_eq("rst_busy", 32'(busy),     0);
    check_eq("rst_done", 32'(done),     0);
    check_eq("rst_idx",  32'(step_idx), 0);
    check_eq("rst_werr", 32'(wr_err),   0);
    #2 rst_n = 1'b1;
    tick();

    // ---- 2: two-entry playback ----
    wr_entry(0, 'h00001, 4'b0000, 1);
    check_eq("idle_wr_noerr", 32'(wr_err), 0);
    wr_entry(1, 'h00001, 4'b0001, 3);
    do_start(2, 1'b0);
    check_eq("t2_c1_key",  32'(key_out), 0);
    check_eq("t2_c1_busy", 32'(busy),    1);
    check_eq("t2_c1_idx",  32'(step_idx),0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_e1_key",  32'(key_out), 1);
      check_eq("t2_e1_busy", 32'(busy),    1);
      check_eq("t2_e1_done", 32'(done),    0);
    end
    tick();
    check_eq("t2_done",     32'(done),    1);
    check_eq("t2_busy_lo",  32'(busy),    0);
    check_eq("t2_key_hold", 32'(key_out), 1);
    tick();
    check_eq("t2_done_pulse", 32'(done),  0);
    check_eq("t2_sw_hold",  32'(sw_out),  1);
    check_eq("t2_idx_hold", 32'(step_idx),1);

    // ---- 3: looping playback and stop ----
    wr_entry(0, 'h10, 1, 2);
    wr_entry(1, 'h11, 2, 2);
    wr_entry(2, 'h12, 3, 2);
    exp_idx = '{0, 0, 1, 1, 2, 2, 0, 0, 1};
    do_start(3, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      check_eq("t3_idx",  32'(step_idx), 32'(exp_idx[i]));
      check_eq("t3_sw",   32'(sw_out),   32'('h10 + exp_idx[i]));
      check_eq("t3_done", 32'(done),     0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("t3_stop_busy", 32'(busy),     0);
    check_eq("t3_stop_done", 32'(done),     0);
    check_eq("t3_stop_sw",   32'(sw_out),   'h11);
    check_eq("t3_stop_idx",  32'(step_idx), 1);
    tick();
    check_eq("t3_stop_done2", 32'(done),    0);
    check_eq("t3_stop_sw2",   32'(sw_out),  'h11);

    // ---- 4: zero steps, zero dwell ----
    do_start(0, 1'b0);
    check_eq("t4_n0_done", 32'(done),   1);
    check_eq("t4_n0_busy", 32'(busy),   0);
    check_eq("t4_n0_sw",   32'(sw_out), 'h11);
    tick();
    check_eq("t4_n0_pulse", 32'(done),  0);
    check_eq("t4_n0_busy2", 32'(busy),  0);
    wr_entry(0, 'h20, 4, 0);
    wr_entry(1, 'h21, 5, 1);
    do_start(2, 1'b0);
    check_eq("t4_dw0_sw",  32'(sw_out), 'h20);
    tick();
    check_eq("t4_e1_sw",   32'(sw_out), 'h21);
    check_eq("t4_e1_busy", 32'(busy),   1);
    tick();
    check_eq("t4_done",    32'(done),   1);
    check_eq("t4_hold_sw", 32'(sw_out), 'h21);

    // ---- 5: write and start while playing ----
    wr_entry(0, 'h30, 6, 3);
    wr_entry(1, 'h31, 7, 1);
    do_start(2, 1'b0);
    check_eq("t5_e0_sw", 32'(sw_out), 'h30);
    wr_en = 1'b1; wr_addr = 1; wr_sw = 'h3F; wr_key = 4'hF; wr_dwell = 1;
    start = 1'b1; num_steps = 1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check_eq("t5_werr",    32'(wr_err), 1);
    check_eq("t5_e0_sw2",  32'(sw_out), 'h30);
    tick();
    check_eq("t5_werr_pulse", 32'(wr_err), 0);
    check_eq("t5_e0_sw3",  32'(sw_out), 'h30);
    tick();
    check_eq("t5_old_sw",  32'(sw_out), 'h31);
    check_eq("t5_old_key", 32'(key_out),7);
    check_eq("t5_idx",     32'(step_idx),1);
    tick();
    check_eq("t5_done",    32'(done),   1);
    check_eq("t5_busy",    32'(busy),   0);

    // ---- 6: clamp to DEPTH, then reset mid-dwell ----
    for (int i = 0; i < DEPTH; i++) wr_entry(i, 'h100 + i, i, 1);
    do_start(DEPTH + 1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) tick();
      check_eq("t6_idx",  32'(step_idx), 32'(i));
      check_eq("t6_sw",   32'(sw_out),   32'('h100 + i));
      check_eq("t6_busy", 32'(busy),     1);
    end
    tick();
    check_eq("t6_done",   32'(done),     1);
    check_eq("t6_busy_lo",32'(busy),     0);
    check_eq("t6_idx_end",32'(step_idx), 15);

    wr_entry(0, 'h2AAAA, 4'hA, 10);
    do_start(1, 1'b0);
    tick(); tick();
    check_eq("t6_mid_sw", 32'(sw_out), 'h2AAAA);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_ar_sw",   32'(sw_out),   0);
    check_eq("t6_ar_key",  32'(key_out),  0);
    check_eq("t6_ar_busy", 32'(busy),     0);
    check_eq("t6_ar_idx",  32'(step_idx), 0);
    check_eq("t6_ar_done", 32'(done),     0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    // Table was cleared: entry 0 is all-zero with dwell 0 (one cycle).
    do_start(1, 1'b0);
    check_eq("t6_clr_sw",   32'(sw_out),  0);
    check_eq("t6_clr_key",  32'(key_out), 0);
    check_eq("t6_clr_busy", 32'(busy),    1);
    tick();
    check_eq("t6_clr_done", 32'(done),    1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
